muldiv_unit: RTL and testbench

Iterative multiply/divide unit that produces the HI/LO results for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
Sits beside the ALU, upstream of the register file write-data mux. MFHI/MFLO select hi_out/lo_out as register write data.
The control unit stalls the PC while busy is high and a dependent MFHI/MFLO is pending.
One radix-2 step per clock: 32 iterations plus one sign-fix/commit cycle.

---
 rtl/muldiv_unit.sv | 106 ++++++++++
 tb/tb_muldiv_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO moves.
// Define MULDIV_FAST_ZERO_EN to skip the iterations for zero multiplies and divide-by-zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state, state_d;
    logic [CW-1:0]      cnt;
    logic               op_div, neg_q, neg_r, div0, fast;
    logic [WIDTH-1:0]   a_mag, b_mag, mag_a, mag_b, quot, rem_src, rem, hi_d, lo_d;
    logic [2*WIDTH-1:0] acc, mul_next, div_next, prod;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic               a_neg, b_neg;

    assign a_neg = op[0] & src_a[WIDTH-1];
    assign b_neg = op[0] & src_b[WIDTH-1];
    assign mag_a = a_neg ? -src_a : src_a;
    assign mag_b = b_neg ? -src_b : src_b;

    // Multiply: add into the upper half when the multiplier LSB is set, then shift right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    // Divide: trial-subtract the shifted remainder; a set quotient bit enters at the LSB.
    assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag};
    assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod    = neg_q ? -acc : acc;
    assign quot    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_src = div0 ? a_mag : acc[2*WIDTH-1:WIDTH];
    assign rem     = neg_r ? -rem_src : rem_src;
    assign hi_d    = op_div ? rem : prod[2*WIDTH-1:WIDTH];
    assign lo_d    = op_div ? (div0 ? '1 : quot) : prod[WIDTH-1:0];

    assign busy = state != IDLE;

    always_comb begin
        fast = 1'b0;
`ifdef MULDIV_FAST_ZERO_EN
        fast = op[1] ? (src_b == '0) : (src_a == '0 || src_b == '0);
`endif
        state_d = state == IDLE ? (start ? (fast ? FINISH : RUN) : IDLE)
                : state == RUN  ? (cnt == CW'(WIDTH-1) ? FINISH : RUN)
                : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_out <= '0;
            lo_out <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= state == FINISH;
            if (state == IDLE) begin
                if (mthi) hi_out <= src_a;
                if (mtlo) lo_out <= src_a;
                if (start) begin
                    op_div <= op[1];
                    a_mag  <= mag_a;
                    b_mag  <= mag_b;
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    div0   <= op[1] & (src_b == '0);
                    // A skipped zero multiply commits straight from a cleared accumulator.
                    acc    <= {{WIDTH{1'b0}}, fast ? {WIDTH{1'b0}} : mag_a};
                    cnt    <= '0;
                end
            end else if (state == RUN) begin
                acc <= op_div ? div_next : mul_next;
                cnt <= cnt + 1'b1;
            end else begin
                hi_out <= hi_d;
                lo_out <= lo_d;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue checked by a done-driven monitor.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, mthi, mtlo, busy, done;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, hi_out, lo_out;
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
`ifdef MULDIV_FAST_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .mthi(mthi), .mtlo(mtlo), .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done hi=%h lo=%h", hi_out, lo_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({hi_out, lo_out} !== e) begin
                    errors++;
                    $display("FAIL result got=%h_%h exp=%h", hi_out, lo_out, e);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit mv);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; mthi = mv; mtlo = mv;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        if (mv) check("move_with_start", {hi_out, lo_out}, {a, a});
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int lat, input int inject_at, input bit mv);
        int cycles = 0;
        int busy_cnt = 0;
        exp_q.push_back({eh, el});
        issue(o, a, b, mv);
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            if (cycles == inject_at) begin
                start = 1'b1; op = 2'b00; src_a = 32'h1234; src_b = 32'h99; mthi = 1'b1; mtlo = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check({name, "_latency"}, 64'(cycles), 64'(lat));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
        @(posedge clk); #1;
        check({name, "_done_single"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd5; mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {hi_out, lo_out}, 64'd0);
        check("reset_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk); start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        check("start_in_reset_ignored", {63'd0, busy}, 64'd0);

        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, -1, 0);
        run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 5, 0);
        run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, -1, 0);
        run_op("div_negdivisor", 2'b11, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, -1, 0);
        run_op("divu_zero", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, ZLAT, -1, 0);
        run_op("div_zero_neg", 2'b11, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF, ZLAT, -1, 0);
        run_op("div_overflow", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, -1, 0);
        run_op("mult_negneg", 2'b01, 32'hFFFFFFFA, 32'hFFFFFFF9, 32'h00000000, 32'd42, 33, -1, 0);
        run_op("multu_shift", 2'b00, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 33, -1, 0);
        run_op("multu_zero_a", 2'b00, 32'd0, 32'd5, 32'd0, 32'd0, ZLAT, -1, 0);
        run_op("mult_zero_b", 2'b01, 32'hFFFFFFFB, 32'd0, 32'd0, 32'd0, ZLAT, -1, 0);
        run_op("multu_move_start", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 33, -1, 1);

        @(negedge clk); mthi = 1'b1; src_a = 32'h1234;
        @(posedge clk); #1; mthi = 1'b0;
        check("mthi_idle", {hi_out, lo_out}, {32'h1234, 32'd42});
        @(negedge clk); mtlo = 1'b1; src_a = 32'h5678;
        @(posedge clk); #1; mtlo = 1'b0;
        check("mtlo_idle", {hi_out, lo_out}, {32'h1234, 32'h5678});
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; src_a = 32'hABCD;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo_idle", {hi_out, lo_out}, {32'hABCD, 32'hABCD});

        issue(2'b10, 32'd1000, 32'd3, 0);
        repeat (10) @(posedge clk);
        #1;
        check("hold_during_run", {hi_out, lo_out}, {32'hABCD, 32'hABCD});
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("midop_reset_regs", {hi_out, lo_out}, 64'd0);
        check("midop_reset_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("no_done_after_reset", {hi_out, lo_out}, 64'd0);
        run_op("divu_after_reset", 2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, 33, -1, 0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
